// File: rtl/kmeans_stream_cluster.sv
// Streaming 2-D k-means engine. It loads a point set, then runs Lloyd assign/update
// iterations until every centroid moves at most the threshold or MAX_ITER is reached.
module kmeans_stream_cluster #(
    parameter int N_MAX    = 16,
    parameter int K        = 2,
    parameter int Q        = 32,
    parameter int MAX_ITER = 8,
    parameter int IW       = $clog2(MAX_ITER + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(N_MAX+1)-1:0] num_points,
    input  logic [Q-1:0]               threshold,
    input  logic                       pt_valid,
    output logic                       pt_ready,
    input  logic [Q-1:0]               pt_x,
    input  logic [Q-1:0]               pt_y,
    output logic                       busy,
    output logic                       done,
    output logic                       converged,
    output logic [IW-1:0]              iter_count,
    output logic [K*Q-1:0]             centroid_x,
    output logic [K*Q-1:0]             centroid_y
);
    localparam int NW = $clog2(N_MAX + 1);
    localparam int AW = $clog2(N_MAX);
    localparam int SW = Q + $clog2(N_MAX);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int DW = $clog2(Q + 1);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, ASSIGN, UPDATE, CHECK, DONE} state_t;
    state_t state_q, state_d;

    logic [NW-1:0] np_q, idx_q;
    logic [Q-1:0]  thr_q, mm_q;
    logic [KW-1:0] k_q;
    logic [DW-1:0] dc_q;
    logic [IW-1:0] iter_q;
    logic          conv_q;
    logic [Q-1:0]  cx_q [K];
    logic [Q-1:0]  cy_q [K];
    logic [Q-1:0]  shx_q [K];
    logic [Q-1:0]  shy_q [K];
    logic [Q-1:0]  slot_x_q [N_MAX];
    logic [Q-1:0]  slot_y_q [N_MAX];
    logic [SW-1:0] sum_x_q [K];
    logic [SW-1:0] sum_y_q [K];
    logic [NW-1:0] cnt_q [K];
    logic [NW-1:0] rem_x_q, rem_y_q;
    logic [Q-1:0]  dvd_x_q, dvd_y_q;

    function automatic logic [Q-1:0] absdiff(input logic [Q-1:0] a, input logic [Q-1:0] b);
        absdiff = (a > b) ? a - b : b - a;
    endfunction

    // One restoring step: shift the next dividend bit into the remainder; the quotient
    // bits fill the dividend register from the bottom as it empties.
    function automatic logic [NW+Q-1:0] div_step(input logic [NW-1:0] rem, input logic [Q-1:0] dvd,
                                                 input logic [NW-1:0] den);
        logic [NW:0] trial;
        trial = {rem, dvd[Q-1]};
        if (trial >= {1'b0, den}) div_step = {NW'(trial - {1'b0, den}), dvd[Q-2:0], 1'b1};
        else                      div_step = {trial[NW-1:0], dvd[Q-2:0], 1'b0};
    endfunction

    logic [NW-1:0]   np_last;
    logic            size_ok, last_div;
    logic [Q-1:0]    px, py;
    logic [KW-1:0]   best;
    logic [Q:0]      best_dist, cur_dist;
    logic [NW+Q-1:0] step_x, step_y;
    logic [Q-1:0]    nx, ny, mv;

    assign np_last  = np_q - NW'(1);
    assign size_ok  = (num_points >= NW'(K)) && (num_points <= NW'(N_MAX));
    assign last_div = (dc_q == DW'(Q));
    assign px       = slot_x_q[idx_q[AW-1:0]];
    assign py       = slot_y_q[idx_q[AW-1:0]];
    assign step_x   = div_step(rem_x_q, dvd_x_q, cnt_q[k_q]);
    assign step_y   = div_step(rem_y_q, dvd_y_q, cnt_q[k_q]);

    always_comb begin
        best      = '0;
        best_dist = {1'b0, absdiff(px, cx_q[0])} + {1'b0, absdiff(py, cy_q[0])};
        cur_dist  = best_dist;
        for (int k = 1; k < K; k++) begin
            cur_dist = {1'b0, absdiff(px, cx_q[k])} + {1'b0, absdiff(py, cy_q[k])};
            if (cur_dist < best_dist) begin
                best_dist = cur_dist;
                best      = KW'(k);
            end
        end
    end

    // An empty cluster keeps its centroid and contributes no movement.
    always_comb begin
        nx = cx_q[k_q];
        ny = cy_q[k_q];
        if (cnt_q[k_q] != '0) begin
            nx = step_x[Q-1:0];
            ny = step_y[Q-1:0];
        end
        mv = (absdiff(nx, cx_q[k_q]) > absdiff(ny, cy_q[k_q])) ? absdiff(nx, cx_q[k_q])
                                                                : absdiff(ny, cy_q[k_q]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pt_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = size_ok ? LOAD : DONE;
            end
            LOAD: begin
                pt_ready = 1'b1;
                if (pt_valid && idx_q == np_last) state_d = INIT;
            end
            INIT:   state_d = ASSIGN;
            ASSIGN: if (idx_q == np_last) state_d = UPDATE;
            UPDATE: if (last_div && k_q == KW'(K - 1)) state_d = CHECK;
            CHECK: begin
                if (mm_q <= thr_q || IW'(iter_q + IW'(1)) == IW'(MAX_ITER)) state_d = DONE;
                else                                                        state_d = ASSIGN;
            end
            DONE: done = 1'b1;
            default: state_d = IDLE;
        endcase
        if (state_q == DONE) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            np_q   <= '0;
            thr_q  <= '0;
            idx_q  <= '0;
            k_q    <= '0;
            dc_q   <= '0;
            iter_q <= '0;
            conv_q <= 1'b0;
            for (int k = 0; k < K; k++) begin
                cx_q[k] <= '0;
                cy_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    np_q   <= num_points;
                    thr_q  <= threshold;
                    iter_q <= '0;
                    conv_q <= 1'b0;
                    idx_q  <= '0;
                end
                LOAD: if (pt_valid) idx_q <= (idx_q == np_last) ? '0 : idx_q + NW'(1);
                INIT: begin
                    for (int k = 0; k < K; k++) begin
                        cx_q[k] <= slot_x_q[AW'(k)];
                        cy_q[k] <= slot_y_q[AW'(k)];
                    end
                    idx_q <= '0;
                end
                ASSIGN: begin
                    idx_q <= (idx_q == np_last) ? '0 : idx_q + NW'(1);
                    k_q   <= '0;
                    dc_q  <= '0;
                end
                UPDATE: begin
                    dc_q <= last_div ? '0 : dc_q + DW'(1);
                    if (last_div) k_q <= (k_q == KW'(K - 1)) ? '0 : k_q + KW'(1);
                end
                CHECK: begin
                    for (int k = 0; k < K; k++) begin
                        cx_q[k] <= shx_q[k];
                        cy_q[k] <= shy_q[k];
                    end
                    iter_q <= iter_q + IW'(1);
                    conv_q <= (mm_q <= thr_q);
                    idx_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state_q)
            LOAD: if (pt_valid) begin
                slot_x_q[idx_q[AW-1:0]] <= pt_x;
                slot_y_q[idx_q[AW-1:0]] <= pt_y;
            end
            INIT, CHECK: for (int k = 0; k < K; k++) begin
                sum_x_q[k] <= '0;
                sum_y_q[k] <= '0;
                cnt_q[k]   <= '0;
            end
            ASSIGN: begin
                sum_x_q[best] <= sum_x_q[best] + SW'(px);
                sum_y_q[best] <= sum_y_q[best] + SW'(py);
                cnt_q[best]   <= cnt_q[best] + NW'(1);
            end
            UPDATE: begin
                // The mean fits in Q bits, so the bits above Q seed the remainder.
                if (dc_q == '0) begin
                    rem_x_q <= NW'(sum_x_q[k_q][SW-1:Q]);
                    rem_y_q <= NW'(sum_y_q[k_q][SW-1:Q]);
                    dvd_x_q <= sum_x_q[k_q][Q-1:0];
                    dvd_y_q <= sum_y_q[k_q][Q-1:0];
                end else begin
                    {rem_x_q, dvd_x_q} <= step_x;
                    {rem_y_q, dvd_y_q} <= step_y;
                    if (last_div) begin
                        shx_q[k_q] <= nx;
                        shy_q[k_q] <= ny;
                        mm_q       <= (k_q == '0 || mv > mm_q) ? mv : mm_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        centroid_x = '0;
        centroid_y = '0;
        for (int k = 0; k < K; k++) begin
            centroid_x[k*Q +: Q] = cx_q[k];
            centroid_y[k*Q +: Q] = cy_q[k];
        end
    end

    assign converged  = conv_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_kmeans_stream_cluster.sv
// Bench for kmeans_stream_cluster: directed vector table, reset and backpressure
// sequences, and randomized runs against a plain-arithmetic Lloyd model.
module tb_kmeans_stream_cluster;
    localparam int N_MAX = 16, K = 2, Q = 32, MAX_ITER = 8, CAP = 2;
    localparam int IW = $clog2(MAX_ITER + 1), IW2 = $clog2(CAP + 1), NW = $clog2(N_MAX + 1);
    localparam int BUDGET = 3000;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, pt_valid = 1'b0;
    logic [NW-1:0] num_points = '0;
    logic [Q-1:0] threshold = '0, pt_x = '0, pt_y = '0;
    logic pt_ready, busy, done, converged;
    logic [IW-1:0] iter_count;
    logic [K*Q-1:0] centroid_x, centroid_y;
    logic pt_ready2, busy2, done2, converged2;
    logic [IW2-1:0] iter_count2;
    logic [K*Q-1:0] centroid_x2, centroid_y2;

    always #5 clk = ~clk;

    kmeans_stream_cluster #(.N_MAX(N_MAX), .K(K), .Q(Q), .MAX_ITER(MAX_ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points), .threshold(threshold),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .busy(busy),
        .done(done), .converged(converged), .iter_count(iter_count),
        .centroid_x(centroid_x), .centroid_y(centroid_y));

    kmeans_stream_cluster #(.N_MAX(N_MAX), .K(K), .Q(Q), .MAX_ITER(CAP)) dut_cap (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points), .threshold(threshold),
        .pt_valid(pt_valid), .pt_ready(pt_ready2), .pt_x(pt_x), .pt_y(pt_y), .busy(busy2),
        .done(done2), .converged(converged2), .iter_count(iter_count2),
        .centroid_x(centroid_x2), .centroid_y(centroid_y2));

    typedef struct {
        string  name;
        int     set_id;
        int     np;
        longint thr;
        bit     gaps;
        longint c0x, c0y, c1x, c1y;
        int     iter;
        bit     conv;
        int     iter_cap;
        bit     conv_cap;
    } vec_t;

    vec_t   tbl[7];
    longint pts_x[N_MAX+1], pts_y[N_MAX+1];
    longint ref_cx[2][K], ref_cy[2][K];
    int     ref_iter[2];
    bit     ref_conv[2];
    int     n_vec = 0, n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Lloyd's algorithm straight from the rules: first K points seed, Manhattan
    // nearest with lowest index on ties, floor mean, empty cluster stays put.
    task automatic ref_model(input int inst, input int np, input longint thr, input int cap);
        longint cx[K], cy[K], nx[K], ny[K], sx[K], sy[K];
        int     cnt[K];
        longint mv, d, bd;
        int     b;
        ref_iter[inst] = 0;
        ref_conv[inst] = 0;
        if (np < K || np > N_MAX) return;
        for (int k = 0; k < K; k++) begin
            cx[k] = pts_x[k];
            cy[k] = pts_y[k];
        end
        while (ref_iter[inst] < cap && !ref_conv[inst]) begin
            for (int k = 0; k < K; k++) begin
                sx[k] = 0; sy[k] = 0; cnt[k] = 0;
            end
            for (int i = 0; i < np; i++) begin
                b = 0; bd = -1;
                for (int k = 0; k < K; k++) begin
                    d = absl(pts_x[i] - cx[k]) + absl(pts_y[i] - cy[k]);
                    if (bd < 0 || d < bd) begin bd = d; b = k; end
                end
                sx[b] += pts_x[i]; sy[b] += pts_y[i]; cnt[b]++;
            end
            mv = 0;
            for (int k = 0; k < K; k++) begin
                nx[k] = (cnt[k] > 0) ? sx[k] / cnt[k] : cx[k];
                ny[k] = (cnt[k] > 0) ? sy[k] / cnt[k] : cy[k];
                if (absl(nx[k] - cx[k]) > mv) mv = absl(nx[k] - cx[k]);
                if (absl(ny[k] - cy[k]) > mv) mv = absl(ny[k] - cy[k]);
            end
            for (int k = 0; k < K; k++) begin
                cx[k] = nx[k]; cy[k] = ny[k];
            end
            ref_iter[inst]++;
            if (mv <= thr) ref_conv[inst] = 1;
        end
        for (int k = 0; k < K; k++) begin
            ref_cx[inst][k] = cx[k];
            ref_cy[inst][k] = cy[k];
        end
    endtask

    task automatic load_set(input int set_id);
        longint s0x[8] = '{0, 2, 0, 2, 100, 102, 100, 102};
        longint s0y[8] = '{0, 0, 2, 2, 100, 100, 102, 102};
        for (int i = 0; i <= N_MAX; i++) begin
            pts_x[i] = (set_id == 0) ? s0x[i % 8] : 5;
            pts_y[i] = (set_id == 0) ? s0y[i % 8] : 5;
        end
    endtask

    task automatic run(input int np, input longint thr, input bit gaps, input string tag);
        int  idx, cyc;
        bit  v, tog, rdy_seen, valid_sz;
        valid_sz = (np >= K && np <= N_MAX);
        ref_model(0, np, thr, MAX_ITER);
        ref_model(1, np, thr, CAP);
        @(negedge clk);
        start = 1'b1; num_points = NW'(np); threshold = Q'(thr);
        @(negedge clk);
        start = 1'b0; cyc = 1;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_busy_rise_cap"}, busy2, 1);
        idx = 0; tog = 1'b0; rdy_seen = 1'b0;
        if (valid_sz) begin
            while (idx < np && cyc < BUDGET) begin
                v = gaps ? tog : 1'b1;
                tog = ~tog;
                pt_x = Q'(pts_x[idx]); pt_y = Q'(pts_y[idx]); pt_valid = v;
                if (v && pt_ready) idx++;
                @(negedge clk); cyc++;
            end
            pt_valid = 1'b0;
            check({tag, "_ready_after_load"}, pt_ready, 0);
            check({tag, "_ready_after_load_cap"}, pt_ready2, 0);
        end
        while (!done && cyc < BUDGET) begin
            if (pt_ready) rdy_seen = 1'b1;
            @(negedge clk); cyc++;
        end
        check({tag, "_done_seen"}, done, 1);
        if (!valid_sz) begin
            check({tag, "_ready_never"}, rdy_seen, 0);
            check({tag, "_latency"}, cyc, 1);
        end else if (!gaps) begin
            check({tag, "_latency"}, cyc, 2 + np + ref_iter[0] * (np + K * (Q + 1) + 1));
        end
        check({tag, "_iter"}, iter_count, ref_iter[0]);
        check({tag, "_conv"}, converged, ref_conv[0]);
        check({tag, "_iter_cap"}, iter_count2, ref_iter[1]);
        check({tag, "_conv_cap"}, converged2, ref_conv[1]);
        for (int k = 0; k < K; k++) begin
            check($sformatf("%s_cx%0d", tag, k), centroid_x[k*Q +: Q], ref_cx[0][k]);
            check($sformatf("%s_cy%0d", tag, k), centroid_y[k*Q +: Q], ref_cy[0][k]);
            check($sformatf("%s_cx%0d_cap", tag, k), centroid_x2[k*Q +: Q], ref_cx[1][k]);
            check($sformatf("%s_cy%0d_cap", tag, k), centroid_y2[k*Q +: Q], ref_cy[1][k]);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_idle_cap"}, {busy2, done2}, 0);
    endtask

    initial begin
        tbl[0] = '{"two_clusters", 0, 8,   0, 1'b0, 1, 1, 101, 101, 3, 1'b1, 2, 1'b0};
        tbl[1] = '{"backpressure", 0, 8,   0, 1'b1, 1, 1, 101, 101, 3, 1'b1, 2, 1'b0};
        tbl[2] = '{"thr100",       0, 8, 100, 1'b0, 0, 1,  68,  67, 1, 1'b1, 1, 1'b1};
        tbl[3] = '{"thr40",        0, 8,  40, 1'b0, 1, 1, 101, 101, 2, 1'b1, 2, 1'b1};
        tbl[4] = '{"tie_empty",    1, 4,   0, 1'b0, 5, 5,   5,   5, 1, 1'b1, 1, 1'b1};
        tbl[5] = '{"too_few",      1, 1,   0, 1'b0, 5, 5,   5,   5, 0, 1'b0, 0, 1'b0};
        tbl[6] = '{"too_many",     1, 17,  0, 1'b0, 5, 5,   5,   5, 0, 1'b0, 0, 1'b0};
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < K; k++) begin ref_cx[i][k] = 0; ref_cy[i][k] = 0; end

        rst = 1'b1;
        #1;
        check("reset_outputs", {pt_ready, busy, done, converged, iter_count}, 0);
        check("reset_centroids", (centroid_x != '0) || (centroid_y != '0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            load_set(tbl[i].set_id);
            run(tbl[i].np, tbl[i].thr, tbl[i].gaps, tbl[i].name);
            check({tbl[i].name, "_tbl_c0x"}, centroid_x[0 +: Q], tbl[i].c0x);
            check({tbl[i].name, "_tbl_c0y"}, centroid_y[0 +: Q], tbl[i].c0y);
            check({tbl[i].name, "_tbl_c1x"}, centroid_x[Q +: Q], tbl[i].c1x);
            check({tbl[i].name, "_tbl_c1y"}, centroid_y[Q +: Q], tbl[i].c1y);
            check({tbl[i].name, "_tbl_iter"}, iter_count, tbl[i].iter);
            check({tbl[i].name, "_tbl_conv"}, converged, tbl[i].conv);
            check({tbl[i].name, "_tbl_iter_cap"}, iter_count2, tbl[i].iter_cap);
            check({tbl[i].name, "_tbl_conv_cap"}, converged2, tbl[i].conv_cap);
            check({tbl[i].name, "_tbl_c1x_cap"}, centroid_x2[Q +: Q], tbl[i].c1x);
        end

        // Reset while the engine is partway through ASSIGN.
        load_set(0);
        @(negedge clk);
        start = 1'b1; num_points = NW'(8); threshold = '0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pt_valid = 1'b1; pt_x = Q'(pts_x[i]); pt_y = Q'(pts_y[i]);
            @(negedge clk);
        end
        pt_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_outputs", {pt_ready, busy, done, converged, iter_count}, 0);
        check("midrun_reset_centroids", (centroid_x != '0) || (centroid_y != '0), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < K; k++) begin ref_cx[i][k] = 0; ref_cy[i][k] = 0; end
        run(8, 0, 1'b0, "after_reset");
        check("after_reset_c1x", centroid_x[Q +: Q], 101);
        check("after_reset_iter", iter_count, 3);

        for (int r = 0; r < 24; r++) begin
            int     np, mode;
            longint thr;
            bit     gaps;
            np = $urandom_range(K, N_MAX);
            if ($urandom_range(0, 7) == 0) np = ($urandom_range(0, 1) == 1) ? 1 : N_MAX + 1;
            mode = $urandom_range(0, 2);
            for (int i = 0; i <= N_MAX; i++) begin
                case (mode)
                    0: begin
                        pts_x[i] = ((i % 3 == 0) ? 1000 : 0) + $urandom_range(0, 50);
                        pts_y[i] = ((i % 2 == 0) ? 700 : 0) + $urandom_range(0, 50);
                    end
                    1: begin
                        pts_x[i] = $urandom_range(0, 255);
                        pts_y[i] = $urandom_range(0, 255);
                    end
                    default: begin
                        pts_x[i] = longint'($urandom);
                        pts_y[i] = longint'($urandom);
                    end
                endcase
            end
            thr  = (mode == 2) ? longint'($urandom_range(0, 1 << 20)) : longint'($urandom_range(0, 3));
            gaps = ($urandom_range(0, 1) == 1);
            run(np, thr, gaps, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
